// File: rtl/hex_digit_scan.sv
// hex_digit_scan: time-multiplexed driver for a 4-digit hex display.
// Digits 0..3 are shown one after another, each for PRESCALE clocks.
// A single-entry pending buffer takes new values. The shown value (disp)
// only changes at a frame boundary or while the scan is off, so a frame
// never mixes two values.
// Optional build macro: LEAD_ZERO_BLANK_EN keeps leading zero digits dark.
`timescale 1ns/1ps
module hex_digit_scan #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  x,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  localparam logic ST_OFF  = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          accept;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    lit;

  // Ready depends only on the buffer state, never on load_valid.
  assign load_ready = ~pend_vld_q;
  assign accept     = load_valid & ~pend_vld_q;
  // A slot only ends while scanning continues; dropping en aborts instead.
  assign slot_end   = (state_q == ST_SCAN) & en & (cnt_q == CNT_LAST);
  assign frame_end  = slot_end & (idx_q == 2'd3);

  // Scan state, prescale counter and digit index; OFF holds both counters at 0.
  always_comb begin
    state_d = en ? ST_SCAN : ST_OFF;
    cnt_d   = '0;
    idx_d   = 2'd0;
    if ((state_q == ST_SCAN) && en) begin
      if (slot_end) begin
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
      end
    end
  end

  // Pending buffer and shown value; disp updates only at frame end or in OFF.
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (state_q == ST_OFF) begin
      if (accept) begin
        disp_d = load_data;
      end else if (pend_vld_q) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (frame_end) begin
      if (pend_vld_q) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
      end else if (accept) begin
        disp_d = load_data;
      end
    end else if (accept) begin
      pend_d     = load_data;
      pend_vld_d = 1'b1;
    end
  end

  // Per-digit lit decision; digit 0 is always lit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lit
      if (gi == 0) begin : g_d0
        assign lit[gi] = 1'b1;
      end else begin : g_dk
`ifdef LEAD_ZERO_BLANK_EN
        assign lit[gi] = |disp_d[15:4*gi];
`else
        assign lit[gi] = 1'b1;
`endif
      end
    end
  endgenerate

  // Outputs are computed from next-state values, so registered x/an match
  // the state and value they belong to, including the first SCAN cycle.
  always_comb begin
    x_d  = 4'h0;
    an_d = 4'b1111;
    if (state_d == ST_SCAN) begin
      x_d         = disp_d[{idx_d, 2'b00} +: 4];
      an_d[idx_d] = ~lit[idx_d];
    end
  end

  assign fd_d = frame_end;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      x_q        <= 4'h0;
      an_q       <= 4'b1111;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      x_q        <= x_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign x          = x_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_digit_scan.sv
// Testbench for hex_digit_scan with PRESCALE=4. Expected frame values are
// queued when the stimulus is driven and popped when a frame is observed.
`timescale 1ns/1ps
module tb_hex_digit_scan;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        load_ready;
  logic [3:0]  x;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  logic [15:0] frame_q[$];

  always #5 clk = ~clk;

  hex_digit_scan #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .x(x), .an(an), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input logic [15:0] v, input int k);
    logic [3:0] a;
    a = 4'b1111;
    a[k] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (k > 0 && (v >> (4 * k)) == 16'h0000) a = 4'b1111;
`endif
    return a;
  endfunction

  // Pops one expected frame value and checks ncyc cycles of it, sampling on
  // the falling edge. first=1 means the frame follows OFF (no frame_done).
  task automatic check_frame(input bit first, input int ncyc);
    logic [15:0] v;
    int k;
    if (frame_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    v = frame_q.pop_front();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      k = c / P;
      chk($sformatf("x f%04h c%0d", v, c), {28'd0, x}, {28'd0, v[4*k +: 4]});
      chk($sformatf("an f%04h c%0d", v, c), {28'd0, an}, {28'd0, exp_an(v, k)});
      chk($sformatf("frame_done f%04h c%0d", v, c), {31'd0, frame_done},
          {31'd0, (c == 0 && !first)});
    end
    $display("frame %04h observed for %0d cycles", v, ncyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked between edges while rst_n is low.
    #12;
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_x", {28'd0, x}, 32'h0);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);
    chk("reset_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Load while OFF goes straight to disp; ready never drops.
    load_data = 16'h1234;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("off_load_ready", {31'd0, load_ready}, 32'd1);
    $display("load 1234 in OFF");
    en = 1'b1;
    frame_q.push_back(16'h1234);
    check_frame(1'b1, 4*P);

    // Mid-frame ABCD then 5678: second one stalls until the boundary.
    frame_q.push_back(16'h1234);
    fork
      check_frame(1'b0, 4*P);
      begin
        repeat (6) @(negedge clk);
        load_data = 16'hABCD;
        load_valid = 1'b1;
        frame_q.push_back(16'hABCD);
        $display("load ABCD mid-frame");
        @(negedge clk);
        chk("ready_drop", {31'd0, load_ready}, 32'd0);
        load_data = 16'h5678;
        frame_q.push_back(16'h5678);
        repeat (9) @(negedge clk);
        chk("stall_ready", {31'd0, load_ready}, 32'd0);
      end
    join
    fork
      check_frame(1'b0, 4*P);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!load_ready && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("stall_bound", {31'd0, (n < 40)}, 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("ready_after_5678", {31'd0, load_ready}, 32'd0);
        $display("load 5678 accepted after stall");
      end
    join
    check_frame(1'b0, 4*P);
    chk("ready_after_copy", {31'd0, load_ready}, 32'd1);

    // en low at digit 2 cycle 1, then restart from digit 0.
    frame_q.push_back(16'h5678);
    check_frame(1'b0, 2*P + 2);
    en = 1'b0;
    @(negedge clk);
    chk("off_an", {28'd0, an}, 32'hF);
    chk("off_x", {28'd0, x}, 32'h0);
    chk("off_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    chk("off_an_hold", {28'd0, an}, 32'hF);
    $display("scan disabled mid-frame");
    en = 1'b1;
    frame_q.push_back(16'h5678);

    // Accept exactly on the frame boundary with pending empty.
    fork
      check_frame(1'b1, 4*P);
      begin
        repeat (4*P) @(negedge clk);
        load_data = 16'h0050;
        load_valid = 1'b1;
        frame_q.push_back(16'h0050);
        $display("load 0050 at frame boundary");
      end
    join
    fork
      check_frame(1'b0, 6);
      begin
        @(negedge clk);
        load_valid = 1'b0;
        chk("boundary_ready", {31'd0, load_ready}, 32'd1);
      end
    join

    // Asynchronous reset pulse between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {28'd0, an}, 32'hF);
    chk("async_x", {28'd0, x}, 32'h0);
    chk("async_ready", {31'd0, load_ready}, 32'd1);
    chk("async_fd", {31'd0, frame_done}, 32'd0);
    #1 rst_n = 1'b1;
    $display("async reset pulse");
    frame_q.push_back(16'h0000);
    check_frame(1'b1, 4*P);

    chk("scoreboard_drained", frame_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
